// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline datapath: operand selects, EX control bits
// and the zero-register index helper.
package arm_pipe_pkg;

    typedef enum logic [1:0] {A_REG, A_MOVZ, A_MOVK, A_MOVN} a_sel_e;
    typedef enum logic [1:0] {B_IMM12, B_REG, B_IMM9, B_ZERO} b_sel_e;

    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
    } ex_ctrl_t;

    // XZR is the highest register index; it reads as the raw regfile value and is never forwarded.
    function automatic int xzr_idx(input int nreg);
        return nreg - 1;
    endfunction

endpackage

// File: rtl/move_wide_unit.sv
// Combinational MOVZ/MOVK/MOVN value builder: places the immediate in the
// lane picked by hw, filling the other lanes with zeros (MOVZ/MOVN) or Db (MOVK).
module move_wide_unit
    import arm_pipe_pkg::*;
#(
    parameter  int XLEN  = 64,
    parameter  int IMM_W = 16,
    localparam int NLANE = XLEN / IMM_W,
    localparam int HW_W  = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic [IMM_W-1:0] i_imm16,
    input  logic [HW_W-1:0]  i_hw,
    input  logic [XLEN-1:0]  i_db,
    input  a_sel_e           i_mode,
    output logic [XLEN-1:0]  o_value
);

    logic [XLEN-1:0] w_movz;
    logic [XLEN-1:0] w_movk;

    for (genvar l = 0; l < NLANE; l++) begin : g_lane
        logic w_hit;
        assign w_hit = (i_hw == HW_W'(l));
        assign w_movz[l*IMM_W +: IMM_W] = w_hit ? i_imm16 : '0;
        assign w_movk[l*IMM_W +: IMM_W] = w_hit ? i_imm16 : i_db[l*IMM_W +: IMM_W];
    end

    always_comb begin
        o_value = w_movz;
        case (i_mode)
            A_MOVK:  o_value = w_movk;
            A_MOVN:  o_value = ~w_movz;
            default: o_value = w_movz;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID->EX operand stage: operand selection, EX/MEM forwarding, load-use stall
// and the EX pipeline register with valid/ready backpressure and flush.
module ex_operand_stage
    import arm_pipe_pkg::*;
#(
    parameter  int XLEN  = 64,
    parameter  int IMM_W = 16,
    parameter  int NREG  = 32,
    localparam int NLANE = XLEN / IMM_W,
    localparam int HW_W  = (NLANE > 1) ? $clog2(NLANE) : 1,
    localparam int RA_W  = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [RA_W-1:0]   i_id_rn,
    input  logic [RA_W-1:0]   i_id_rb,
    input  logic [XLEN-1:0]   i_id_da,
    input  logic [XLEN-1:0]   i_id_db,
    input  logic [RA_W-1:0]   i_id_rd,
    input  logic              i_id_regwrite,
    input  logic              i_id_memread,
    input  logic [1:0]        i_id_a_sel,
    input  logic [1:0]        i_id_b_sel,
    input  logic [11:0]       i_id_imm12,
    input  logic [8:0]        i_id_imm9,
    input  logic [IMM_W-1:0]  i_id_imm16,
    input  logic [HW_W-1:0]   i_id_hw,
    input  logic              i_flush,
    input  logic [XLEN-1:0]   i_ex_alu_out,
    input  logic [RA_W-1:0]   i_mem_rd,
    input  logic              i_mem_regwrite,
    input  logic [XLEN-1:0]   i_mem_wdata,
    output logic              o_ex_valid,
    input  logic              i_ex_ready,
    output logic [XLEN-1:0]   o_ex_op_a,
    output logic [XLEN-1:0]   o_ex_op_b,
    output logic [XLEN-1:0]   o_ex_store_data,
    output logic [RA_W-1:0]   o_ex_rd,
    output logic              o_ex_regwrite,
    output logic              o_ex_memread
);

    localparam logic [RA_W-1:0] XZR = RA_W'(xzr_idx(NREG));

    typedef struct packed {
        ex_ctrl_t        ctrl;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [XLEN-1:0] store_data;
    } ex_reg_t;

    ex_reg_t         r_ex;
    ex_reg_t         w_ex_next;
    a_sel_e          w_a_sel;
    b_sel_e          w_b_sel;
    logic            w_ex_fwd_ok;
    logic [XLEN-1:0] w_fwd_da;
    logic [XLEN-1:0] w_fwd_db;
    logic [XLEN-1:0] w_mw_value;
    logic            w_uses_rb;
    logic            w_hazard;
    logic            w_advance;
    logic            w_load;

    assign w_a_sel = a_sel_e'(i_id_a_sel);
    assign w_b_sel = b_sel_e'(i_id_b_sel);

    // A load in EX has no result yet, so only non-load producers forward from EX.
    assign w_ex_fwd_ok = r_ex.ctrl.valid & r_ex.ctrl.regwrite & ~r_ex.ctrl.memread;

    assign w_fwd_da = (i_id_rn == XZR)                          ? i_id_da      :
                      (w_ex_fwd_ok && r_ex.rd == i_id_rn)       ? i_ex_alu_out :
                      (i_mem_regwrite && i_mem_rd == i_id_rn)   ? i_mem_wdata  : i_id_da;

    assign w_fwd_db = (i_id_rb == XZR)                          ? i_id_db      :
                      (w_ex_fwd_ok && r_ex.rd == i_id_rb)       ? i_ex_alu_out :
                      (i_mem_regwrite && i_mem_rd == i_id_rb)   ? i_mem_wdata  : i_id_db;

    move_wide_unit #(.XLEN(XLEN), .IMM_W(IMM_W)) u_move_wide (
        .i_imm16 (i_id_imm16),
        .i_hw    (i_id_hw),
        .i_db    (w_fwd_db),
        .i_mode  (w_a_sel),
        .o_value (w_mw_value)
    );

    // Db is read by register-operand ALU ops, MOVK, and stores (IMM9 without memread).
    assign w_uses_rb = (w_b_sel == B_REG) | (w_a_sel == A_MOVK) |
                       (~i_id_memread & (w_b_sel == B_IMM9));

    assign w_hazard = i_id_valid & r_ex.ctrl.valid & r_ex.ctrl.memread & r_ex.ctrl.regwrite &
                      (r_ex.rd != XZR) &
                      (((r_ex.rd == i_id_rn) & (w_a_sel == A_REG)) |
                       ((r_ex.rd == i_id_rb) & w_uses_rb));

    assign w_advance  = ~r_ex.ctrl.valid | i_ex_ready;
    assign w_load     = i_id_valid & ~i_flush & ~w_hazard;
    assign o_id_ready = (w_advance & ~w_hazard) | i_flush;

    always_comb begin
        w_ex_next                = r_ex;
        w_ex_next.ctrl.valid     = 1'b1;
        w_ex_next.ctrl.regwrite  = i_id_regwrite;
        w_ex_next.ctrl.memread   = i_id_memread;
        w_ex_next.rd             = i_id_rd;
        w_ex_next.store_data     = w_fwd_db;
        w_ex_next.op_a           = (w_a_sel == A_REG) ? w_fwd_da : w_mw_value;
        w_ex_next.op_b           = '0;
        if (w_a_sel == A_REG) begin
            case (w_b_sel)
                B_IMM12: w_ex_next.op_b = {{(XLEN-12){1'b0}}, i_id_imm12};
                B_REG:   w_ex_next.op_b = w_fwd_db;
                B_IMM9:  w_ex_next.op_b = {{(XLEN-9){i_id_imm9[8]}}, i_id_imm9};
                default: w_ex_next.op_b = '0;
            endcase
        end
    end

    // Bubbles clear only the control bits; data fields keep their value to avoid toggling.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ex <= '0;
        end else if (w_advance) begin
            if (w_load) begin
                r_ex <= w_ex_next;
            end else begin
                r_ex.ctrl <= '0;
            end
        end
    end

    assign o_ex_valid      = r_ex.ctrl.valid;
    assign o_ex_regwrite   = r_ex.ctrl.regwrite;
    assign o_ex_memread    = r_ex.ctrl.memread;
    assign o_ex_rd         = r_ex.rd;
    assign o_ex_op_a       = r_ex.op_a;
    assign o_ex_op_b       = r_ex.op_b;
    assign o_ex_store_data = r_ex.store_data;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: table of operand-select vectors plus
// hand-written forwarding, load-use, backpressure/flush and async-reset sequences.
module tb_ex_operand_stage;
    import arm_pipe_pkg::*;

    localparam int XLEN  = 64;
    localparam int IMM_W = 16;
    localparam int NREG  = 32;
    localparam int HW_W  = 2;
    localparam int RA_W  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid;
    logic              id_ready;
    logic [RA_W-1:0]   id_rn, id_rb, id_rd;
    logic [XLEN-1:0]   id_da, id_db;
    logic              id_regwrite, id_memread;
    logic [1:0]        id_a_sel, id_b_sel;
    logic [11:0]       id_imm12;
    logic [8:0]        id_imm9;
    logic [IMM_W-1:0]  id_imm16;
    logic [HW_W-1:0]   id_hw;
    logic              flush;
    logic [XLEN-1:0]   ex_alu_out;
    logic [RA_W-1:0]   mem_rd;
    logic              mem_regwrite;
    logic [XLEN-1:0]   mem_wdata;
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_op_a, ex_op_b, ex_store_data;
    logic [RA_W-1:0]   ex_rd;
    logic              ex_regwrite, ex_memread;

    ex_operand_stage #(.XLEN(XLEN), .IMM_W(IMM_W), .NREG(NREG)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_id_valid(id_valid), .o_id_ready(id_ready),
        .i_id_rn(id_rn), .i_id_rb(id_rb), .i_id_da(id_da), .i_id_db(id_db), .i_id_rd(id_rd),
        .i_id_regwrite(id_regwrite), .i_id_memread(id_memread),
        .i_id_a_sel(id_a_sel), .i_id_b_sel(id_b_sel), .i_id_imm12(id_imm12),
        .i_id_imm9(id_imm9), .i_id_imm16(id_imm16), .i_id_hw(id_hw), .i_flush(flush),
        .i_ex_alu_out(ex_alu_out), .i_mem_rd(mem_rd), .i_mem_regwrite(mem_regwrite),
        .i_mem_wdata(mem_wdata), .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
        .o_ex_op_a(ex_op_a), .o_ex_op_b(ex_op_b), .o_ex_store_data(ex_store_data),
        .o_ex_rd(ex_rd), .o_ex_regwrite(ex_regwrite), .o_ex_memread(ex_memread)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic [1:0] a_sel, input logic [1:0] b_sel,
                          input logic [RA_W-1:0] rn, input logic [RA_W-1:0] rb,
                          input logic [XLEN-1:0] da, input logic [XLEN-1:0] db,
                          input logic [RA_W-1:0] rd, input logic regwrite, input logic memread);
        id_valid    = 1'b1;
        id_a_sel    = a_sel;
        id_b_sel    = b_sel;
        id_rn       = rn;
        id_rb       = rb;
        id_da       = da;
        id_db       = db;
        id_rd       = rd;
        id_regwrite = regwrite;
        id_memread  = memread;
    endtask

    typedef struct {
        logic [1:0]       a_sel;
        logic [1:0]       b_sel;
        logic [XLEN-1:0]  da;
        logic [XLEN-1:0]  db;
        logic [11:0]      imm12;
        logic [8:0]       imm9;
        logic [IMM_W-1:0] imm16;
        logic [HW_W-1:0]  hw;
        logic [XLEN-1:0]  exp_a;
        logic [XLEN-1:0]  exp_b;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // a_sel: 0 REG 1 MOVZ 2 MOVK 3 MOVN; b_sel: 0 IMM12 1 REG 2 IMM9 3 ZERO
        vecs[0] = '{2'd1, 2'd0, 64'h0, 64'h0123, 12'h123, 9'h0, 16'hBEEF, 2'd2,
                    64'h0000_BEEF_0000_0000, 64'h0};
        vecs[1] = '{2'd3, 2'd2, 64'h0, 64'h0, 12'h0, 9'h1FF, 16'hBEEF, 2'd0,
                    64'hFFFF_FFFF_FFFF_4110, 64'h0};
        vecs[2] = '{2'd2, 2'd1, 64'h0, 64'h1111_2222_3333_4444, 12'h0, 9'h0, 16'hBEEF, 2'd3,
                    64'hBEEF_2222_3333_4444, 64'h0};
        vecs[3] = '{2'd0, 2'd2, 64'hDEAD, 64'h0, 12'h0, 9'h1FF, 16'h0, 2'd0,
                    64'hDEAD, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[4] = '{2'd0, 2'd0, 64'h42, 64'h0, 12'hFFF, 9'h0, 16'h0, 2'd0,
                    64'h42, 64'h0000_0000_0000_0FFF};
        vecs[5] = '{2'd0, 2'd1, 64'h1, 64'hCAFE_F00D, 12'h7, 9'h0, 16'h0, 2'd0,
                    64'h1, 64'hCAFE_F00D};
        vecs[6] = '{2'd0, 2'd3, 64'h2, 64'h99, 12'h7, 9'h7, 16'h0, 2'd0,
                    64'h2, 64'h0};
        vecs[7] = '{2'd0, 2'd2, 64'h3, 64'h0, 12'h0, 9'h0FF, 16'h0, 2'd0,
                    64'h3, 64'h0000_0000_0000_00FF};
        vecs[8] = '{2'd1, 2'd3, 64'h0, 64'h5, 12'h0, 9'h0, 16'h1234, 2'd0,
                    64'h0000_0000_0000_1234, 64'h0};

        id_set(2'd0, 2'd3, 5'd0, 5'd0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0);
        id_valid = 1'b0; id_imm12 = '0; id_imm9 = '0; id_imm16 = '0; id_hw = '0;
        flush = 1'b0; ex_alu_out = '0; mem_rd = '0; mem_regwrite = 1'b0;
        mem_wdata = '0; ex_ready = 1'b1;

        // reset state
        #2;
        chk("rst_ex_valid", 64'(ex_valid), 64'h0);
        chk("rst_op_a", ex_op_a, 64'h0);
        chk("rst_op_b", ex_op_b, 64'h0);
        chk("rst_id_ready", 64'(id_ready), 64'h1);
        #10 rst_n = 1'b1;
        tick();

        // operand-select table; producers never write so no forwarding applies
        for (int i = 0; i < 9; i++) begin
            id_set(vecs[i].a_sel, vecs[i].b_sel, 5'd20, 5'd21, vecs[i].da, vecs[i].db,
                   5'(i), 1'b0, 1'b0);
            id_imm12 = vecs[i].imm12;
            id_imm9  = vecs[i].imm9;
            id_imm16 = vecs[i].imm16;
            id_hw    = vecs[i].hw;
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(ex_valid), 64'h1);
            chk($sformatf("vec%0d_op_a", i), ex_op_a, vecs[i].exp_a);
            chk($sformatf("vec%0d_op_b", i), ex_op_b, vecs[i].exp_b);
            chk($sformatf("vec%0d_st", i), ex_store_data, vecs[i].db);
            chk($sformatf("vec%0d_rd", i), 64'(ex_rd), 64'(i));
        end

        // forwarding: ADD X1 into EX, then a reader of X1
        id_set(2'd0, 2'd3, 5'd7, 5'd7, 64'h10, 64'h0, 5'd1, 1'b1, 1'b0);
        tick();
        id_set(2'd0, 2'd1, 5'd1, 5'd1, 64'h0, 64'h0, 5'd8, 1'b0, 1'b0);
        ex_alu_out = 64'd5; mem_rd = 5'd1; mem_regwrite = 1'b1; mem_wdata = 64'd7;
        tick();
        chk("fwd_ex_op_a", ex_op_a, 64'd5);
        chk("fwd_ex_op_b", ex_op_b, 64'd5);
        chk("fwd_ex_st", ex_store_data, 64'd5);
        tick();
        chk("fwd_mem_op_a", ex_op_a, 64'd7);
        chk("fwd_mem_st", ex_store_data, 64'd7);
        id_set(2'd0, 2'd1, 5'd31, 5'd31, 64'h99, 64'h77, 5'd8, 1'b0, 1'b0);
        mem_rd = 5'd31;
        tick();
        chk("fwd_xzr_op_a", ex_op_a, 64'h99);
        chk("fwd_xzr_st", ex_store_data, 64'h77);
        mem_regwrite = 1'b0;

        // load-use: LDUR X2, then ADD X3,X2,X4
        id_set(2'd0, 2'd2, 5'd9, 5'd9, 64'h1000, 64'h0, 5'd2, 1'b1, 1'b1);
        id_imm9 = 9'd8;
        tick();
        chk("ld_memread", 64'(ex_memread), 64'h1);
        id_set(2'd0, 2'd1, 5'd2, 5'd4, 64'h0, 64'h4, 5'd3, 1'b1, 1'b0);
        #1;
        chk("ld_use_stall", 64'(id_ready), 64'h0);
        tick();
        chk("ld_bubble_valid", 64'(ex_valid), 64'h0);
        chk("ld_bubble_regwrite", 64'(ex_regwrite), 64'h0);
        chk("ld_bubble_memread", 64'(ex_memread), 64'h0);
        chk("ld_use_resume", 64'(id_ready), 64'h1);
        mem_rd = 5'd2; mem_regwrite = 1'b1; mem_wdata = 64'h55;
        tick();
        chk("ld_fwd_op_a", ex_op_a, 64'h55);
        chk("ld_fwd_op_b", ex_op_b, 64'h4);
        chk("ld_fwd_rd", 64'(ex_rd), 64'd3);
        mem_regwrite = 1'b0;

        // load into XZR never stalls a reader of X31
        id_set(2'd0, 2'd2, 5'd9, 5'd9, 64'h1000, 64'h0, 5'd31, 1'b1, 1'b1);
        tick();
        id_set(2'd0, 2'd1, 5'd31, 5'd31, 64'h0, 64'h0, 5'd5, 1'b1, 1'b0);
        #1;
        chk("ld_xzr_no_stall", 64'(id_ready), 64'h1);
        // MOVZ ignores Rn, so a matching Rn from a load is not a hazard
        id_set(2'd0, 2'd0, 5'd31, 5'd6, 64'h0, 64'h0, 5'd5, 1'b1, 1'b0);
        tick();
        id_set(2'd0, 2'd2, 5'd9, 5'd9, 64'h0, 64'h0, 5'd12, 1'b1, 1'b1);
        tick();
        id_set(2'd1, 2'd0, 5'd12, 5'd13, 64'h0, 64'h0, 5'd5, 1'b1, 1'b0);
        #1;
        chk("movz_no_stall", 64'(id_ready), 64'h1);
        tick();

        // backpressure with a flush while EX is held
        id_set(2'd0, 2'd0, 5'd10, 5'd10, 64'hAAAA, 64'h0, 5'd6, 1'b1, 1'b0);
        id_imm12 = 12'h005;
        tick();
        chk("bp_load_op_a", ex_op_a, 64'hAAAA);
        ex_ready = 1'b0;
        id_set(2'd0, 2'd0, 5'd11, 5'd11, 64'hBBBB, 64'h0, 5'd7, 1'b1, 1'b0);
        #1;
        chk("bp_c1_id_ready", 64'(id_ready), 64'h0);
        tick();
        chk("bp_c1_op_a", ex_op_a, 64'hAAAA);
        chk("bp_c1_rd", 64'(ex_rd), 64'd6);
        flush = 1'b1;
        #1;
        chk("bp_c2_flush_ready", 64'(id_ready), 64'h1);
        tick();
        chk("bp_c2_valid", 64'(ex_valid), 64'h1);
        chk("bp_c2_op_a", ex_op_a, 64'hAAAA);
        chk("bp_c2_op_b", ex_op_b, 64'h5);
        flush = 1'b0;
        id_valid = 1'b0;
        tick();
        chk("bp_c3_op_a", ex_op_a, 64'hAAAA);
        chk("bp_c3_regwrite", 64'(ex_regwrite), 64'h1);
        ex_ready = 1'b1;
        tick();
        chk("bp_rel_bubble", 64'(ex_valid), 64'h0);
        chk("bp_rel_regwrite", 64'(ex_regwrite), 64'h0);
        chk("bp_rel_hold_data", ex_op_a, 64'hAAAA);

        // async reset mid-stream
        id_set(2'd0, 2'd0, 5'd14, 5'd14, 64'h1234, 64'h0, 5'd9, 1'b1, 1'b0);
        id_imm12 = 12'h00F;
        tick();
        chk("pre_rst_valid", 64'(ex_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(ex_valid), 64'h0);
        chk("async_rst_op_a", ex_op_a, 64'h0);
        chk("async_rst_op_b", ex_op_b, 64'h0);
        chk("async_rst_rd", 64'(ex_rd), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
